reward_timer: RTL and testbench
===============================

Name: reward_timer

Overview:
- Producer side of the reward-item status interface consumed by the on-screen item-information renderer.
- Latches a pickup event and asserts exactly one item flag (invincible, frozen, faster, laser).
- Counts elapsed seconds on item_cnt, then expires the item.
- The renderer draws a remaining-time bar of length (DURATION - item_cnt).

Parameters:
TICK_DIV, 100000000, clk cycles per item_cnt increment (1 s at 100 MHz); must be >= 2
DURATION, 30, ticks an item stays active; 1..1023

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
enable_reward  input  1  reward feature enable; low forces idle
pause  input  1  game paused; freezes timing
pickup_valid  input  1  single-cycle pickup strobe from the collision logic
pickup_type  input  2  item code: 0 invincible, 1 frozen, 2 faster, 3 laser
item_cnt  output  10  elapsed ticks of the active item; 0 when idle
item_invincible  output  1  invincible item active
item_frozen  output  1  frozen item active
item_faster  output  1  faster item active
item_laser  output  1  laser item active
item_expired  output  1  one-cycle pulse on natural expiry

Behaviour:
- Reset: state IDLE, prescaler 0, item_cnt 0, all four flags 0, item_expired 0. All outputs are registered.
- Flags are one-hot or all zero. All zero exactly in IDLE.
- FSM states: IDLE, ACTIVE.
- IDLE + enable_reward + pickup_valid at edge N:
  - From edge N: ACTIVE, flag for pickup_type = 1, item_cnt = 0, prescaler = 0.
  - Latency: one cycle from strobe to flag.
- ACTIVE, enable_reward=1, pause=0: prescaler increments each cycle. At TICK_DIV-1 it wraps to 0 and raises an internal tick.
- ACTIVE + tick, item_cnt < DURATION-1: item_cnt increments by 1.
- ACTIVE + tick, item_cnt == DURATION-1:
  - Next state IDLE; flags 0; item_cnt 0; item_expired = 1 for exactly one cycle.
  - The item is therefore active for DURATION*TICK_DIV cycles.
- pause=1: prescaler and item_cnt hold, flags hold, no tick. A pickup while paused is still accepted.
- Pickup while ACTIVE, either the same or a different type:
  - Replaces the current item; only the new flag is set next cycle.
  - item_cnt = 0 and prescaler = 0 (full restart).
  - No item_expired pulse.
- Pickup coinciding with the final tick: the pickup wins. New item starts with item_cnt = 0; no item_expired.
- enable_reward=0, any state: next cycle IDLE with outputs as after reset. No item_expired pulse; pickup_valid is ignored.
- rst has priority over every other input, including mid-item.
- Arithmetic:
  - Prescaler width is $clog2(TICK_DIV).
  - item_cnt is a 10-bit unsigned value and never exceeds DURATION-1, so it cannot wrap.
  - Compare against DURATION-1 explicitly; no sign extension.

Decomposition:
- Shared package:
  - ITEM_INVINCIBLE/FROZEN/FASTER/LASER = 2'd0..2'd3
  - DEFAULT_DURATION = 30
  - 12-bit colour constants used by the renderer
  - FSM state encoding
- Sub-module reward_tick_gen (parameter TICK_DIV):
  - Inputs clk, rst, clear, hold.
  - Output: a one-cycle tick.
  - clear has priority over hold.
- Top contains the FSM, item register, item_cnt counter and expiry pulse.

Test Plan (TICK_DIV=4, DURATION=3 unless noted):
1. Reset: hold rst 3 cycles with pickup_valid=1 -> all flags 0, item_cnt 0, item_expired 0 throughout.
2. Full item: pickup_type=3 strobe at cycle 0 -> item_laser=1 from cycle 1 with item_cnt=0.
   - item_cnt=1 at cycle 5, item_cnt=2 at cycle 9.
   - At cycle 13: item_laser=0, item_cnt=0, item_expired=1 for one cycle only.
3. Replace: laser active with item_cnt=2, strobe pickup_type=1 -> next cycle item_laser=0, item_frozen=1, item_cnt=0. Expiry occurs 12 cycles later.
4. Pause: pause=1 for 10 cycles at item_cnt=1 -> item_cnt stays 1 and flag held. After release, the next increment comes 4 - (prescaler value at pause) cycles later.
5. Disable: drop enable_reward mid-item -> next cycle all outputs 0 with no item_expired. A pickup_valid while disabled produces no flag.
6. Collision: pickup_type=0 strobe on the same cycle as the final tick -> item_invincible=1, item_cnt=0, item_expired stays 0. Repeat with DURATION=30, TICK_DIV=2 to confirm item_cnt reaches 29, then expires at cycle 61.

Source files
------------

// File: rtl/reward_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module : reward_timer_pkg
// Brief  : Shared item codes, durations, renderer colours and FSM encoding
//          for the reward-item timer and its consumers.
// Rev    : 1.0  initial release
// ============================================================================
package reward_timer_pkg;

  localparam logic [1:0] ITEM_INVINCIBLE = 2'd0;
  localparam logic [1:0] ITEM_FROZEN     = 2'd1;
  localparam logic [1:0] ITEM_FASTER     = 2'd2;
  localparam logic [1:0] ITEM_LASER      = 2'd3;

  localparam int DEFAULT_DURATION = 30;

  // 12-bit RGB colours the renderer uses for each item and its timer bar
  localparam logic [11:0] COLOR_INVINCIBLE = 12'hFF0;
  localparam logic [11:0] COLOR_FROZEN     = 12'h0FF;
  localparam logic [11:0] COLOR_FASTER     = 12'h0F0;
  localparam logic [11:0] COLOR_LASER      = 12'hF00;
  localparam logic [11:0] COLOR_BAR_BG     = 12'h333;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Flag vector bit order: {laser, faster, frozen, invincible}
  function automatic logic [3:0] item_onehot(input logic [1:0] code);
    return 4'b0001 << code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reward_timer_if.sv
`default_nettype none
// ============================================================================
// Module : reward_timer_if
// Brief  : Game-side control inputs and item-status outputs of the reward
//          timer. master = game/renderer side, slave = reward_timer.
// Rev    : 1.0  initial release
// ============================================================================
interface reward_timer_if;

  logic       enable_reward;
  logic       pause;
  logic       pickup_valid;
  logic [1:0] pickup_type;
  logic [9:0] item_cnt;
  logic       item_invincible;
  logic       item_frozen;
  logic       item_faster;
  logic       item_laser;
  logic       item_expired;

  modport master (
    output enable_reward, pause, pickup_valid, pickup_type,
    input  item_cnt, item_invincible, item_frozen, item_faster, item_laser,
           item_expired
  );

  modport slave (
    input  enable_reward, pause, pickup_valid, pickup_type,
    output item_cnt, item_invincible, item_frozen, item_faster, item_laser,
           item_expired
  );

endinterface
`default_nettype wire

// File: rtl/reward_timer_tick_gen.sv
`default_nettype none
// ============================================================================
// Module : reward_tick_gen
// Brief  : Prescaler producing a one-cycle tick every TICK_DIV enabled
//          cycles. clear restarts from zero and beats hold.
// Rev    : 1.0  initial release
// ============================================================================
module reward_tick_gen #(
  parameter int TICK_DIV = 100000000
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clear,
  input  wire logic hold,
  output logic      tick
);

  localparam int              CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;
  logic             at_last;

  assign at_last = (count == LAST);
  // A tick is only reported on a cycle where the count actually wraps
  assign tick    = at_last && !hold && !clear;

  // Prescaler: restart on rst/clear, freeze on hold, wrap at TICK_DIV-1
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (!hold) begin
      if (at_last) count <= '0;
      else         count <= count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/reward_timer.sv
`default_nettype none
// ============================================================================
// Module : reward_timer
// Brief  : Latches a reward pickup, raises one item flag, counts elapsed
//          ticks on item_cnt and expires the item after DURATION ticks.
// Rev    : 1.0  initial release
// ============================================================================
module reward_timer
  import reward_timer_pkg::*;
#(
  parameter int TICK_DIV = 100000000,
  parameter int DURATION = DEFAULT_DURATION
) (
  input  wire logic     clk,
  input  wire logic     rst,
  reward_timer_if.slave bus
);

  localparam logic [9:0] LAST_CNT = 10'(DURATION - 1);

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic [9:0] cnt_q,   cnt_d;
  logic       expired_q, expired_d;
  logic       tick;
  logic       presc_clear;

  // Prescaler sits at zero while idle, disabled, or restarting on a pickup
  assign presc_clear = !bus.enable_reward || bus.pickup_valid ||
                       (state_q == ST_IDLE);

  reward_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (presc_clear),
    .hold  (bus.pause),
    .tick  (tick)
  );

  // Next-state logic: disable beats pickup, pickup beats the final tick
  always_comb begin
    state_d   = state_q;
    flags_d   = flags_q;
    cnt_d     = cnt_q;
    expired_d = 1'b0;
    if (!bus.enable_reward) begin
      state_d = ST_IDLE;
      flags_d = 4'b0000;
      cnt_d   = 10'd0;
    end else if (bus.pickup_valid) begin
      state_d = ST_ACTIVE;
      flags_d = item_onehot(bus.pickup_type);
      cnt_d   = 10'd0;
    end else if ((state_q == ST_ACTIVE) && tick) begin
      if (cnt_q == LAST_CNT) begin
        state_d   = ST_IDLE;
        flags_d   = 4'b0000;
        cnt_d     = 10'd0;
        expired_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 10'd1;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      flags_q   <= 4'b0000;
      cnt_q     <= 10'd0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign bus.item_cnt        = cnt_q;
  assign bus.item_invincible = flags_q[0];
  assign bus.item_frozen     = flags_q[1];
  assign bus.item_faster     = flags_q[2];
  assign bus.item_laser      = flags_q[3];
  assign bus.item_expired    = expired_q;

endmodule
`default_nettype wire

// File: tb/tb_reward_timer.sv
`default_nettype none
// ============================================================================
// Module : tb_reward_timer
// Brief  : Directed self-checking bench for reward_timer. dut_a runs with
//          TICK_DIV=4/DURATION=3, dut_b with TICK_DIV=2/DURATION=30.
// Rev    : 1.0  initial release
// ============================================================================
module tb_reward_timer;

  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_INV  = 4'b0001;
  localparam logic [3:0] F_FRZ  = 4'b0010;
  localparam logic [3:0] F_FAST = 4'b0100;
  localparam logic [3:0] F_LAS  = 4'b1000;

  typedef struct {
    string      tag;
    logic [3:0] flags;
    logic [9:0] cnt;
    logic       expired;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  reward_timer_if bus_a ();
  reward_timer_if bus_b ();

  reward_timer #(.TICK_DIV(4), .DURATION(3)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  reward_timer #(.TICK_DIV(2), .DURATION(30)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic compare(input exp_t e, input logic [3:0] f, input logic [9:0] c,
                         input logic x);
    checks++;
    assert ({f, c, x} === {e.flags, e.cnt, e.expired}) else begin
      errors++;
      $error("FAIL %s: got flags=%b cnt=%0d expired=%b, want flags=%b cnt=%0d expired=%b",
             e.tag, f, c, x, e.flags, e.cnt, e.expired);
    end
  endtask

  // Push the expectation, clock one edge, then pop and compare against dut_a
  task automatic step_a(input string tag, input logic [3:0] f, input logic [9:0] c,
                        input logic x);
    exp_t e;
    q_a.push_back('{tag, f, c, x});
    step();
    e = q_a.pop_front();
    compare(e, {bus_a.item_laser, bus_a.item_faster, bus_a.item_frozen,
                bus_a.item_invincible}, bus_a.item_cnt, bus_a.item_expired);
  endtask

  task automatic step_b(input string tag, input logic [3:0] f, input logic [9:0] c,
                        input logic x);
    exp_t e;
    q_b.push_back('{tag, f, c, x});
    step();
    e = q_b.pop_front();
    compare(e, {bus_b.item_laser, bus_b.item_faster, bus_b.item_frozen,
                bus_b.item_invincible}, bus_b.item_cnt, bus_b.item_expired);
  endtask

  initial begin
    rst                 = 1'b1;
    bus_a.enable_reward = 1'b1;
    bus_a.pause         = 1'b0;
    bus_a.pickup_valid  = 1'b1;
    bus_a.pickup_type   = 2'd3;
    bus_b.enable_reward = 1'b1;
    bus_b.pause         = 1'b0;
    bus_b.pickup_valid  = 1'b1;
    bus_b.pickup_type   = 2'd3;

    // 1. reset dominates a pending pickup
    for (int i = 0; i < 3; i++) step_a("reset", F_NONE, 10'd0, 1'b0);
    rst                = 1'b0;
    bus_a.pickup_valid = 1'b0;
    bus_b.pickup_valid = 1'b0;
    step_a("post_reset_idle", F_NONE, 10'd0, 1'b0);

    // 2. full laser item: cnt steps at cycles 5 and 9, expiry at cycle 13
    bus_a.pickup_valid = 1'b1;
    bus_a.pickup_type  = 2'd3;
    step_a("full_c1", F_LAS, 10'd0, 1'b0);
    bus_a.pickup_valid = 1'b0;
    for (int k = 2; k <= 12; k++) step_a("full_run", F_LAS, 10'((k - 1) / 4), 1'b0);
    step_a("full_expire", F_NONE, 10'd0, 1'b1);
    step_a("full_after", F_NONE, 10'd0, 1'b0);

    // 3. replace laser at cnt=2 with frozen
    bus_a.pickup_valid = 1'b1;
    bus_a.pickup_type  = 2'd3;
    step_a("repl_start", F_LAS, 10'd0, 1'b0);
    bus_a.pickup_valid = 1'b0;
    for (int k = 2; k <= 9; k++) step_a("repl_run", F_LAS, 10'((k - 1) / 4), 1'b0);
    bus_a.pickup_valid = 1'b1;
    bus_a.pickup_type  = 2'd1;
    step_a("repl_swap", F_FRZ, 10'd0, 1'b0);
    bus_a.pickup_valid = 1'b0;
    for (int r = 2; r <= 12; r++) step_a("repl_frozen", F_FRZ, 10'((r - 1) / 4), 1'b0);
    step_a("repl_expire", F_NONE, 10'd0, 1'b1);

    // 4. pause at cnt=1 with prescaler=1, then a paused pickup
    bus_a.pickup_valid = 1'b1;
    bus_a.pickup_type  = 2'd2;
    step_a("pause_start", F_FAST, 10'd0, 1'b0);
    bus_a.pickup_valid = 1'b0;
    for (int r = 2; r <= 6; r++) step_a("pause_run", F_FAST, 10'((r - 1) / 4), 1'b0);
    bus_a.pause = 1'b1;
    for (int i = 0; i < 10; i++) step_a("pause_hold", F_FAST, 10'd1, 1'b0);
    bus_a.pause = 1'b0;
    step_a("pause_rel1", F_FAST, 10'd1, 1'b0);
    step_a("pause_rel2", F_FAST, 10'd1, 1'b0);
    step_a("pause_rel3", F_FAST, 10'd2, 1'b0);
    bus_a.pause        = 1'b1;
    bus_a.pickup_valid = 1'b1;
    bus_a.pickup_type  = 2'd0;
    step_a("pause_pickup", F_INV, 10'd0, 1'b0);
    bus_a.pickup_valid = 1'b0;
    bus_a.pause        = 1'b0;

    // 5. disable mid-item, pickup ignored while disabled, reset mid-item
    step_a("dis_pre1", F_INV, 10'd0, 1'b0);
    step_a("dis_pre2", F_INV, 10'd0, 1'b0);
    bus_a.enable_reward = 1'b0;
    step_a("dis_drop", F_NONE, 10'd0, 1'b0);
    bus_a.pickup_valid = 1'b1;
    bus_a.pickup_type  = 2'd3;
    step_a("dis_pickup", F_NONE, 10'd0, 1'b0);
    bus_a.pickup_valid = 1'b0;
    step_a("dis_hold", F_NONE, 10'd0, 1'b0);
    bus_a.enable_reward = 1'b1;
    step_a("dis_reen", F_NONE, 10'd0, 1'b0);
    bus_a.pickup_valid = 1'b1;
    bus_a.pickup_type  = 2'd1;
    step_a("rst_mid_start", F_FRZ, 10'd0, 1'b0);
    bus_a.pickup_valid = 1'b0;
    rst = 1'b1;
    step_a("rst_mid", F_NONE, 10'd0, 1'b0);
    rst = 1'b0;
    step_a("rst_mid_after", F_NONE, 10'd0, 1'b0);

    // 6. pickup on the final tick wins over expiry
    bus_a.pickup_valid = 1'b1;
    bus_a.pickup_type  = 2'd3;
    step_a("coll_start", F_LAS, 10'd0, 1'b0);
    bus_a.pickup_valid = 1'b0;
    for (int r = 2; r <= 12; r++) step_a("coll_run", F_LAS, 10'((r - 1) / 4), 1'b0);
    bus_a.pickup_valid = 1'b1;
    bus_a.pickup_type  = 2'd0;
    step_a("coll_win", F_INV, 10'd0, 1'b0);
    bus_a.pickup_valid = 1'b0;
    for (int i = 0; i < 3; i++) step_a("coll_after", F_INV, 10'd0, 1'b0);

    // 6b. long item on dut_b: cnt reaches 29, expiry at cycle 61
    bus_b.pickup_valid = 1'b1;
    bus_b.pickup_type  = 2'd3;
    step_b("long_c1", F_LAS, 10'd0, 1'b0);
    bus_b.pickup_valid = 1'b0;
    for (int k = 2; k <= 60; k++) step_b("long_run", F_LAS, 10'((k - 1) / 2), 1'b0);
    step_b("long_expire", F_NONE, 10'd0, 1'b1);
    step_b("long_after", F_NONE, 10'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
